// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
//   Bundles the requester handshakes (video, CPU, DMA) and the single
//   controller port shared by the arbiter.
//   slave  : arbiter side  (takes requests and controller read data,
//            drives acks, read data and the controller request bus)
//   master : requester / controller side (the mirror image)
interface sdram_arbiter_if;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        vid_ack;
    logic [63:0] vid_dout64;

    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [1:0]  cpu_ds;
    logic [15:0] cpu_din;
    logic        cpu_ack;
    logic [15:0] cpu_dout;

    logic        dma_req;
    logic        dma_we;
    logic [23:0] dma_addr;
    logic [1:0]  dma_ds;
    logic [15:0] dma_din;
    logic        dma_ack;
    logic [15:0] dma_dout;

    logic        ram_req;
    logic        ram_we;
    logic [23:0] ram_addr;
    logic [1:0]  ram_ds;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [63:0] ram_dout64;

    modport slave (
        input  vid_req, vid_addr,
        output vid_ack, vid_dout64,
        input  cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_din,
        output cpu_ack, cpu_dout,
        input  dma_req, dma_we, dma_addr, dma_ds, dma_din,
        output dma_ack, dma_dout,
        output ram_req, ram_we, ram_addr, ram_ds, ram_din,
        input  ram_dout, ram_dout64
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_ack, vid_dout64,
        output cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_din,
        input  cpu_ack, cpu_dout,
        output dma_req, dma_we, dma_addr, dma_ds, dma_din,
        input  dma_ack, dma_dout,
        input  ram_req, ram_we, ram_addr, ram_ds, ram_din,
        output ram_dout, ram_dout64
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single cpu/chipset port of the 96 MHz SDRAM controller
//   between video (4-word burst reads), CPU and DMA. One request is granted
//   per 12-phase slot and held on the controller bus for the whole slot;
//   completion (data capture + one-cycle ack) happens at the end of the slot.
//   A refresh slot is forced after REFRESH_MAX consecutive granted slots.
//   Ports:
//     clk_96   : 96 MHz clock
//     init     : synchronous active-high reset
//     clk_8_en : 8 MHz enable; its rising edge re-aligns the slot phase
//     bus      : requester handshakes and controller port (slave modport)
module sdram_arbiter #(
    parameter int unsigned REFRESH_MAX = 32,
    parameter int unsigned SLOT_LAST   = 11
) (
    input  logic             clk_96,
    input  logic             init,
    input  logic             clk_8_en,
    sdram_arbiter_if.slave   bus
);
    localparam int unsigned BW = $clog2(REFRESH_MAX + 1);
    localparam logic [BW-1:0] BUSY_MAX = BW'(REFRESH_MAX);

    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA} owner_t;
    typedef enum logic {RR_CPU, RR_DMA} rr_t;

    logic [3:0]    r_p;
    logic          r_en_d;
    owner_t        r_owner, w_owner_nxt;
    rr_t           r_rr, w_rr_nxt;
    logic [BW-1:0] r_busy, w_busy_nxt;
    logic          w_slot_end;

    logic          r_ram_req, r_ram_we;
    logic [23:0]   r_ram_addr;
    logic [1:0]    r_ram_ds;
    logic [15:0]   r_ram_din;
    logic          w_req_nxt, w_we_nxt;
    logic [23:0]   w_addr_nxt;
    logic [1:0]    w_ds_nxt;
    logic [15:0]   w_din_nxt;

    logic          r_vid_ack, r_cpu_ack, r_dma_ack;
    logic [63:0]   r_vid_dout64;
    logic [15:0]   r_cpu_dout, r_dma_dout;

    assign w_slot_end = (r_p == 4'(SLOT_LAST));

    // Phase counter mirrors the controller: the cycle after clk_8_en rises
    // it sits at SLOT_LAST-1, so the slot boundary follows two cycles later.
    always_ff @(posedge clk_96) begin
        if (init) begin
            r_p    <= '0;
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= clk_8_en;
            if (clk_8_en && !r_en_d)
                r_p <= 4'(SLOT_LAST - 1);
            else if (w_slot_end)
                r_p <= '0;
            else
                r_p <= r_p + 4'd1;
        end
    end

    // State register: slot owner, round-robin pointer, busy-slot count.
    always_ff @(posedge clk_96) begin
        if (init) begin
            r_owner <= OWN_NONE;
            r_rr    <= RR_CPU;
            r_busy  <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state: grant decision taken only at the slot boundary.
    always_comb begin
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_busy_nxt  = r_busy;
        if (w_slot_end) begin
            w_owner_nxt = OWN_NONE;
            w_busy_nxt  = '0;
            if (r_busy != BUSY_MAX) begin
                if (bus.vid_req) begin
                    w_owner_nxt = OWN_VID;
                end else if (bus.cpu_req && bus.dma_req) begin
                    w_owner_nxt = (r_rr == RR_CPU) ? OWN_CPU : OWN_DMA;
                    w_rr_nxt    = (r_rr == RR_CPU) ? RR_DMA : RR_CPU;
                end else if (bus.cpu_req) begin
                    w_owner_nxt = OWN_CPU;
                    w_rr_nxt    = RR_DMA;
                end else if (bus.dma_req) begin
                    w_owner_nxt = OWN_DMA;
                    w_rr_nxt    = RR_CPU;
                end
                if (w_owner_nxt != OWN_NONE)
                    w_busy_nxt = r_busy + BW'(1);
            end
        end
    end

    // Output decode: controller bus contents for the next slot's owner.
    always_comb begin
        w_req_nxt  = 1'b0;
        w_we_nxt   = 1'b0;
        w_addr_nxt = r_ram_addr;
        w_ds_nxt   = r_ram_ds;
        w_din_nxt  = r_ram_din;
        case (w_owner_nxt)
            OWN_VID: begin
                w_req_nxt  = 1'b1;
                w_addr_nxt = bus.vid_addr;
                w_ds_nxt   = 2'b11;
            end
            OWN_CPU: begin
                w_req_nxt  = 1'b1;
                w_we_nxt   = bus.cpu_we;
                w_addr_nxt = bus.cpu_addr;
                w_ds_nxt   = bus.cpu_ds;
                w_din_nxt  = bus.cpu_din;
            end
            OWN_DMA: begin
                w_req_nxt  = 1'b1;
                w_we_nxt   = bus.dma_we;
                w_addr_nxt = bus.dma_addr;
                w_ds_nxt   = bus.dma_ds;
                w_din_nxt  = bus.dma_din;
            end
            default: ;
        endcase
    end

    // Registered outputs: completion of the ending slot and launch of the
    // next one share the same boundary edge.
    always_ff @(posedge clk_96) begin
        if (init) begin
            r_ram_req    <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_ds     <= '0;
            r_ram_din    <= '0;
            r_vid_ack    <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_vid_dout64 <= '0;
            r_cpu_dout   <= '0;
            r_dma_dout   <= '0;
        end else begin
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            if (w_slot_end) begin
                case (r_owner)
                    OWN_VID: begin
                        r_vid_ack    <= 1'b1;
                        r_vid_dout64 <= bus.ram_dout64;
                    end
                    OWN_CPU: begin
                        r_cpu_ack <= 1'b1;
                        if (!r_ram_we) r_cpu_dout <= bus.ram_dout;
                    end
                    OWN_DMA: begin
                        r_dma_ack <= 1'b1;
                        if (!r_ram_we) r_dma_dout <= bus.ram_dout;
                    end
                    default: ;
                endcase
                r_ram_req  <= w_req_nxt;
                r_ram_we   <= w_we_nxt;
                r_ram_addr <= w_addr_nxt;
                r_ram_ds   <= w_ds_nxt;
                r_ram_din  <= w_din_nxt;
            end
        end
    end

    assign bus.ram_req    = r_ram_req;
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_ds     = r_ram_ds;
    assign bus.ram_din    = r_ram_din;
    assign bus.vid_ack    = r_vid_ack;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.dma_ack    = r_dma_ack;
    assign bus.vid_dout64 = r_vid_dout64;
    assign bus.cpu_dout   = r_cpu_dout;
    assign bus.dma_dout   = r_dma_dout;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter. u_dut uses default parameters;
//   u_dut_r uses REFRESH_MAX=4 for the refresh-slot pattern.
//   After do_reset the phase is 0, so the k-th edge leaves phase k and the
//   12th edge is the first slot boundary.
module tb_sdram_arbiter;
    logic clk  = 1'b0;
    logic init = 1'b1;
    logic en   = 1'b0;
    logic en_r = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ovl    = 0;

    sdram_arbiter_if bus ();
    sdram_arbiter_if bus_r ();

    sdram_arbiter u_dut (
        .clk_96   (clk),
        .init     (init),
        .clk_8_en (en),
        .bus      (bus)
    );

    sdram_arbiter #(.REFRESH_MAX(4)) u_dut_r (
        .clk_96   (clk),
        .init     (init),
        .clk_8_en (en_r),
        .bus      (bus_r)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!init && (int'(bus.vid_ack) + int'(bus.cpu_ack) + int'(bus.dma_ack)) > 1)
            n_ovl++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        init = 1'b1;
        step(1);
        init = 1'b0;
    endtask

    localparam logic [23:0] VA = 24'h000100;
    localparam logic [23:0] CA = 24'h000200;
    localparam logic [23:0] DA = 24'h000300;

    logic [23:0] exp_addr [6];
    logic [2:0]  exp_ack  [6];
    logic [3:0]  seen;
    int          good;
    logic        ack_seen;

    initial begin
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_ds = '0; bus.cpu_din = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_ds = '0; bus.dma_din = '0;
        bus.ram_dout = '0; bus.ram_dout64 = '0;
        bus_r.vid_req = 0; bus_r.vid_addr = '0;
        bus_r.cpu_req = 0; bus_r.cpu_we = 0; bus_r.cpu_addr = 24'h000042; bus_r.cpu_ds = 2'b11; bus_r.cpu_din = '0;
        bus_r.dma_req = 0; bus_r.dma_we = 0; bus_r.dma_addr = '0; bus_r.dma_ds = '0; bus_r.dma_din = '0;
        bus_r.ram_dout = '0; bus_r.ram_dout64 = '0;

        // Reset state and three idle slots
        do_reset();
        check("rst_ram_req", bus.ram_req, 0);
        check("rst_acks", {bus.vid_ack, bus.cpu_ack, bus.dma_ack}, 0);
        seen = '0;
        for (int i = 0; i < 36; i++) begin
            step(1);
            seen |= {bus.ram_req, bus.vid_ack, bus.cpu_ack, bus.dma_ack};
        end
        check("idle_activity", seen, 0);
        check("idle_vid_dout", bus.vid_dout64, 0);
        check("idle_cpu_dout", bus.cpu_dout, 0);
        check("idle_dma_dout", bus.dma_dout, 0);

        // CPU read, request withdrawn after grant so it is serviced once
        do_reset();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 24'h000123; bus.cpu_ds = 2'b11;
        bus.ram_dout = 16'hBEEF;
        step(12);
        good = 0; ack_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.ram_req && !bus.ram_we && bus.ram_addr == 24'h000123) good++;
            ack_seen |= bus.cpu_ack;
            if (i == 0) bus.cpu_req = 0;
            step(1);
        end
        check("cpu_rd_stable", good, 12);
        check("cpu_rd_early_ack", ack_seen, 0);
        check("cpu_rd_ack", bus.cpu_ack, 1);
        check("cpu_rd_dout", bus.cpu_dout, 16'hBEEF);
        check("cpu_rd_next_idle", bus.ram_req, 0);
        step(1);
        check("cpu_rd_ack_pulse", bus.cpu_ack, 0);

        // Priority: video first, then CPU/DMA round robin
        do_reset();
        exp_addr = '{VA, VA, CA, DA, CA, DA};
        exp_ack  = '{3'b000, 3'b100, 3'b100, 3'b010, 3'b001, 3'b010};
        bus.vid_addr = VA; bus.cpu_addr = CA; bus.dma_addr = DA;
        bus.cpu_we = 0; bus.dma_we = 0; bus.cpu_ds = 2'b11; bus.dma_ds = 2'b11;
        bus.ram_dout = 16'h1111; bus.ram_dout64 = 64'h0123_4567_89AB_CDEF;
        bus.vid_req = 1; bus.cpu_req = 1; bus.dma_req = 1;
        n_ovl = 0;
        for (int i = 0; i < 6; i++) begin
            step(12);
            check($sformatf("arb_addr%0d", i), bus.ram_addr, exp_addr[i]);
            check($sformatf("arb_ack%0d", i), {bus.vid_ack, bus.cpu_ack, bus.dma_ack}, exp_ack[i]);
            if (i == 1) begin
                check("vid_ds", bus.ram_ds, 2'b11);
                check("vid_dout64", bus.vid_dout64, 64'h0123_4567_89AB_CDEF);
                bus.vid_req = 0;
            end
        end
        bus.cpu_req = 0; bus.dma_req = 0;
        step(12);
        check("arb_last_ack", {bus.vid_ack, bus.cpu_ack, bus.dma_ack}, 3'b001);
        check("arb_cpu_dout", bus.cpu_dout, 16'h1111);
        check("ack_overlap", n_ovl, 0);

        // DMA write: bus stable for the slot, dout untouched
        do_reset();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 24'h000456;
        bus.dma_ds = 2'b01; bus.dma_din = 16'h00A5;
        bus.ram_dout = 16'hDEAD;
        step(12);
        good = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.ram_req && bus.ram_we && bus.ram_ds == 2'b01 &&
                bus.ram_din == 16'h00A5 && bus.ram_addr == 24'h000456) good++;
            if (i == 0) bus.dma_req = 0;
            step(1);
        end
        check("dma_wr_stable", good, 12);
        check("dma_wr_ack", bus.dma_ack, 1);
        check("dma_wr_dout", bus.dma_dout, 0);

        // Refresh slot insertion with REFRESH_MAX=4
        do_reset();
        bus_r.cpu_req = 1;
        for (int i = 0; i < 10; i++) begin
            step(12);
            check($sformatf("refresh_slot%0d", i), bus_r.ram_req, ((i % 5) != 4));
        end
        bus_r.cpu_req = 0;

        // Reset during a granted CPU read
        do_reset();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 24'h000321; bus.cpu_ds = 2'b11;
        step(12);
        check("rst_mid_granted", bus.ram_req, 1);
        step(5);
        init = 1;
        step(1);
        check("rst_mid_req", bus.ram_req, 0);
        init = 0;
        seen = '0;
        for (int i = 0; i < 11; i++) begin
            step(1);
            seen |= {bus.ram_req, bus.vid_ack, bus.cpu_ack, bus.dma_ack};
        end
        check("rst_mid_quiet", seen, 0);
        step(1);
        check("rst_mid_first_grant", bus.ram_req, 1);
        bus.cpu_req = 0;

        // clk_8_en realignment: boundary two edges after the rise is seen
        do_reset();
        step(3);
        en = 1;
        step(1);
        bus.cpu_req = 1; bus.cpu_addr = 24'h000777;
        step(1);
        check("realign_before", bus.ram_req, 0);
        step(1);
        check("realign_grant", bus.ram_addr, 24'h000777);
        bus.cpu_req = 0;
        step(12);
        check("realign_ack", bus.cpu_ack, 1);
        en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
